// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - opcodes and saturation-limit helper shared by the addsub_pipe slice
package addsub_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ACC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam int LIM_W = 64;

    // Upper or lower representable value of an acc_w-bit signed/unsigned number.
    function automatic logic [LIM_W-1:0] sat_limit(input int acc_w, input logic is_signed,
                                                   input logic upper);
        logic [LIM_W-1:0] w_one;
        w_one = 64'd1;
        if (is_signed)
            return upper ? ((w_one << (acc_w - 1)) - 64'd1) : ~((w_one << (acc_w - 1)) - 64'd1);
        else
            return upper ? ((w_one << acc_w) - 64'd1) : '0;
    endfunction

endpackage

// File: rtl/addsub_sat.sv
// rtl/addsub_sat.sv - ACC_W add/sub with overflow detect; clamps when ADDSUB_PIPE_SAT_EN is defined
module addsub_sat import addsub_pkg::*; #(
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b1
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    input  logic             i_sub,
    input  logic             i_clamp,
    output logic [ACC_W-1:0] o_result,
    output logic             o_overflow
);

    logic [ACC_W:0] w_raw;
    logic           w_ovf_s;

    // Extra top bit is the unsigned carry (add) or borrow (sub).
    assign w_raw = i_sub ? ({1'b0, i_a} - {1'b0, i_b}) : ({1'b0, i_a} + {1'b0, i_b});

    assign w_ovf_s = (i_sub ? (i_a[ACC_W-1] != i_b[ACC_W-1]) : (i_a[ACC_W-1] == i_b[ACC_W-1]))
                     && (w_raw[ACC_W-1] != i_a[ACC_W-1]);

    assign o_overflow = SIGNED ? w_ovf_s : w_raw[ACC_W];

`ifdef ADDSUB_PIPE_SAT_EN
    logic             w_to_hi;
    logic [ACC_W-1:0] w_lim_hi;
    logic [ACC_W-1:0] w_lim_lo;

    // Signed overflow direction follows operand A's sign; unsigned follows add vs sub.
    assign w_to_hi  = SIGNED ? !i_a[ACC_W-1] : !i_sub;
    assign w_lim_hi = ACC_W'(sat_limit(ACC_W, SIGNED, 1'b1));
    assign w_lim_lo = ACC_W'(sat_limit(ACC_W, SIGNED, 1'b0));
    assign o_result = (i_clamp && o_overflow) ? (w_to_hi ? w_lim_hi : w_lim_lo) : w_raw[ACC_W-1:0];
`else
    logic w_unused_clamp;
    assign w_unused_clamp = i_clamp;
    assign o_result       = w_raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - two-stage add/sub/accumulate pipe; ADDSUB_PIPE_SAT_EN enables ACC saturation
module addsub_pipe import addsub_pkg::*; #(
    parameter int W      = 16,
    parameter int ACC_W  = 24,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     dataa,
    input  logic [W-1:0]     datab,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             overflow
);

    logic             w_adv;
    logic             w_is_acc;
    logic [ACC_W-1:0] w_a_ext;
    logic [ACC_W-1:0] w_b_ext;
    logic [ACC_W-1:0] w_op_a;
    logic [ACC_W-1:0] w_op_b;
    logic [ACC_W-1:0] w_sum;
    logic             w_sum_ovf;

    logic             r_s1_valid;
    logic [ACC_W-1:0] r_s1_a;
    logic [ACC_W-1:0] r_s1_b;
    logic [1:0]       r_s1_op;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_result;
    logic             r_overflow;
    logic             r_out_valid;

    // A single advance enable keeps both stages and the accumulator frozen under stall.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    assign w_a_ext = SIGNED ? {{(ACC_W-W){dataa[W-1]}}, dataa} : {{(ACC_W-W){1'b0}}, dataa};
    assign w_b_ext = SIGNED ? {{(ACC_W-W){datab[W-1]}}, datab} : {{(ACC_W-W){1'b0}}, datab};

    assign w_is_acc = (r_s1_op == OP_ACC);
    assign w_op_a   = w_is_acc ? r_acc  : r_s1_a;
    assign w_op_b   = w_is_acc ? r_s1_a : r_s1_b;

    addsub_sat #(.ACC_W(ACC_W), .SIGNED(SIGNED)) u_sat (
        .i_a        (w_op_a),
        .i_b        (w_op_b),
        .i_sub      (r_s1_op == OP_SUB),
        .i_clamp    (w_is_acc),
        .o_result   (w_sum),
        .o_overflow (w_sum_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_op     <= OP_ADD;
            r_acc       <= '0;
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            r_s1_a      <= w_a_ext;
            r_s1_b      <= w_b_ext;
            r_s1_op     <= op;
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                if (r_s1_op == OP_LOAD) begin
                    r_result   <= r_s1_a;
                    r_overflow <= 1'b0;
                    r_acc      <= r_s1_a;
                end else begin
                    r_result   <= w_sum;
                    r_overflow <= w_sum_ovf;
                    if (w_is_acc)
                        r_acc <= w_sum;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - bench for addsub_pipe: signed and unsigned instances against an integer model
module tb_addsub_pipe;

    localparam int W     = 16;
    localparam int ACC_W = 24;
    localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

    typedef struct {
        logic [ACC_W-1:0] res;
        logic             ov;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             out_ready;
    logic [W-1:0]     dataa;
    logic [W-1:0]     datab;
    logic [1:0]       op;
    logic             in_ready_s, out_valid_s, ov_s;
    logic             in_ready_u, out_valid_u, ov_u;
    logic [ACC_W-1:0] res_s, res_u;

    always #5 clk = ~clk;

    addsub_pipe #(.W(W), .ACC_W(ACC_W), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .dataa(dataa), .datab(datab), .op(op), .out_valid(out_valid_s),
        .out_ready(out_ready), .result(res_s), .overflow(ov_s)
    );

    addsub_pipe #(.W(W), .ACC_W(ACC_W), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_u),
        .dataa(dataa), .datab(datab), .op(op), .out_valid(out_valid_u),
        .out_ready(out_ready), .result(res_u), .overflow(ov_u)
    );

    int               n_pass = 0;
    int               n_total = 0;
    int               cyc = 0;
    int               stall_cnt = 0;
    exp_t             q_s[$], q_u[$], log_s[$], log_u[$];
    int               log_cyc[$];
    exp_t             m_e;
    longint           acc_s = 0, acc_u = 0;
    logic             stall_s = 1'b0, stall_u = 1'b0;
    logic [ACC_W-1:0] prev_s, prev_u;
    logic             prev_ov_s, prev_ov_u;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Exact integer arithmetic, then range test and wrap (or clamp for ACC when saturating).
    task automatic model(input bit sg, input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input longint acc_in, output exp_t e, output longint acc_out);
        longint av, bv, v, lo, hi;
        av = sg ? longint'($signed(a)) : longint'(a);
        bv = sg ? longint'($signed(b)) : longint'(b);
        hi = sg ? (longint'(1) << (ACC_W-1)) - 1 : (longint'(1) << ACC_W) - 1;
        lo = sg ? -(longint'(1) << (ACC_W-1)) : 0;
        case (o)
            ADD:     v = av + bv;
            SUB:     v = av - bv;
            ACC:     v = acc_in + av;
            default: v = av;
        endcase
        e.ov = (v < lo) || (v > hi);
`ifdef ADDSUB_PIPE_SAT_EN
        if (o == ACC) v = (v > hi) ? hi : ((v < lo) ? lo : v);
`endif
        e.res   = v[ACC_W-1:0];
        acc_out = acc_in;
        if (o == ACC || o == LOAD) acc_out = sg ? longint'($signed(e.res)) : longint'(e.res);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            q_s.delete();
            q_u.delete();
            acc_s   = 0;
            acc_u   = 0;
            stall_s = 1'b0;
            stall_u = 1'b0;
        end else begin
            check("in_ready_rule_s", in_ready_s, !out_valid_s || out_ready);
            check("in_ready_rule_u", in_ready_u, !out_valid_u || out_ready);
            if (stall_s) begin
                check("hold_valid_s", out_valid_s, 1);
                check("hold_res_s", res_s, prev_s);
                check("hold_ov_s", ov_s, prev_ov_s);
            end
            if (stall_u) begin
                check("hold_valid_u", out_valid_u, 1);
                check("hold_res_u", res_u, prev_u);
                check("hold_ov_u", ov_u, prev_ov_u);
            end
            if (out_valid_s && out_ready) begin
                log_s.push_back('{res_s, ov_s});
                log_cyc.push_back(cyc);
                check("pending_s", q_s.size() > 0, 1);
                if (q_s.size() > 0) begin
                    m_e = q_s.pop_front();
                    check("res_s", res_s, m_e.res);
                    check("ov_s", ov_s, m_e.ov);
                end
            end
            if (out_valid_u && out_ready) begin
                log_u.push_back('{res_u, ov_u});
                check("pending_u", q_u.size() > 0, 1);
                if (q_u.size() > 0) begin
                    m_e = q_u.pop_front();
                    check("res_u", res_u, m_e.res);
                    check("ov_u", ov_u, m_e.ov);
                end
            end
            if (in_valid && in_ready_s) begin
                model(1'b1, op, dataa, datab, acc_s, m_e, acc_s);
                q_s.push_back(m_e);
            end
            if (in_valid && in_ready_u) begin
                model(1'b0, op, dataa, datab, acc_u, m_e, acc_u);
                q_u.push_back(m_e);
            end
            stall_s   = out_valid_s && !out_ready;
            stall_u   = out_valid_u && !out_ready;
            prev_s    = res_s;
            prev_u    = res_u;
            prev_ov_s = ov_s;
            prev_ov_u = ov_u;
            if (stall_s) stall_cnt++;
        end
    end

    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        bit ok = 1'b0;
        in_valid = 1'b1;
        op       = o;
        dataa    = a;
        datab    = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready_s;
            @(posedge clk);
            #1;
        end
        check("send_accepted", ok, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n0, n1, sc0, ovc_s, ovc_u;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = ADD; dataa = '0; datab = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", out_valid_s, 0);
        check("reset_result", res_s, 0);
        check("reset_overflow", ov_s, 0);
        check("reset_in_ready", in_ready_s, 1);
        @(posedge clk);
        #1;

        send(ADD, 16'h7FFF, 16'h0001);
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_one_cycle_valid", out_valid_s, 0);
        @(negedge clk);
        check("lat_two_cycle_valid", out_valid_s, 1);
        check("add_res", res_s, 24'h008000);
        check("add_ov", ov_s, 0);
        idle(2);

        n0 = log_s.size();
        n1 = log_u.size();
        send(SUB, 16'h0000, 16'h0001);
        idle(4);
        check("sub_res_s", log_s[n0].res, 24'hFFFFFF);
        check("sub_ov_s", log_s[n0].ov, 0);
        check("sub_res_u", log_u[n1].res, 24'hFFFFFF);
        check("sub_ov_u", log_u[n1].ov, 1);

        n0 = log_s.size();
        send(LOAD, 16'd100, 16'd0);
        for (int k = 0; k < 3; k++) send(ACC, 16'd50, 16'd0);
        idle(4);
        for (int k = 0; k < 4; k++) begin
            check("load_acc_res", log_s[n0+k].res, 100 + 50 * k);
            check("load_acc_cycle", log_cyc[n0+k], log_cyc[n0] + k);
        end

        n0  = log_s.size();
        sc0 = stall_cnt;
        fork
            begin
                send(LOAD, 16'd0, 16'd0);
                for (int k = 0; k < 10; k++) send(ACC, 16'd1, 16'd0);
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        idle(4);
        check("stall_beats", log_s.size() - n0, 11);
        check("stall_final_acc", log_s[log_s.size()-1].res, 10);
        check("stall_cycles", stall_cnt - sc0, 3);

        n0 = log_s.size();
        n1 = log_u.size();
        send(LOAD, 16'h7FFF, 16'd0);
        for (int k = 0; k < 300; k++) send(ACC, 16'h7FFF, 16'd0);
        idle(4);
        check("acc300_beats", log_s.size() - n0, 301);
        ovc_s = 0;
        ovc_u = 0;
        for (int k = 1; k <= 300; k++) begin
            if (log_s[n0+k].ov) ovc_s++;
            if (log_u[n1+k].ov) ovc_u++;
        end
        check("acc300_first_ovf_flag", log_s[n0+256].ov, 1);
        check("acc300_last_clean", log_s[n0+255].res, 24'h7FFF00);
`ifdef ADDSUB_PIPE_SAT_EN
        check("acc300_first_ovf_res", log_s[n0+256].res, 24'h7FFFFF);
        check("acc300_final_res", log_s[n0+300].res, 24'h7FFFFF);
        check("acc300_ovf_count", ovc_s, 45);
`else
        check("acc300_first_ovf_res", log_s[n0+256].res, 24'h807EFF);
        check("acc300_final_res", log_s[n0+300].res, 24'h967ED3);
        check("acc300_ovf_count", ovc_s, 1);
`endif
        check("acc300_final_res_u", log_u[n1+300].res, 24'h967ED3);
        check("acc300_ovf_count_u", ovc_u, 0);

        n0 = log_s.size();
        send(LOAD, 16'd500, 16'd0);
        idle(4);
        check("rst_preload", log_s[n0].res, 500);
        send(ACC, 16'd1, 16'd0);
        send(ACC, 16'd2, 16'd0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid_s, 0);
        check("rst_result", res_s, 0);
        check("rst_in_ready", in_ready_s, 1);
        @(posedge clk);
        #1;
        n0 = log_s.size();
        n1 = log_u.size();
        send(ACC, 16'd7, 16'd0);
        idle(4);
        check("rst_acc7_s", log_s[n0].res, 7);
        check("rst_acc7_u", log_u[n1].res, 7);
        check("rst_acc7_beats", log_s.size() - n0, 1);

        check("drained_s", q_s.size(), 0);
        check("drained_u", q_u.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
